// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline sequencer and the stage registers:
// stall/exception/halt requests in, stall vector, flush redirect and halt status out.
interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        exc_req;
  logic [31:0] exc_pc;
  logic        halt_req;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        halt_ack;
  logic [1:0]  state_o;
  logic        stall_timeout;

  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem, exc_req, exc_pc, halt_req,
    input  stall, flush, new_pc, halt_ack, state_o, stall_timeout
  );

  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem, exc_req, exc_pc, halt_req,
    output stall, flush, new_pc, halt_ack, state_o, stall_timeout
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: stall vector, exception flush/redirect, halt/drain handshake.
// Optional stall watchdog enabled by defining PIPE_STALL_WDOG_EN.
module pipe_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 3,
  parameter int STALL_MAX    = 255,
  parameter int WDOG_W       = 8
) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             flush_r;
  logic             halt_ack_r;
  logic [31:0]      new_pc_r;
  logic [31:0]      new_pc_nxt_s;
  logic [5:0]       base_s;
  logic [5:0]       stall_s;
  logic             drain_adv_s;

  // Base stall request decode, deepest stage wins
  always_comb begin
    base_s = 6'b000000;
    if (bus.stallreq_mem) begin
      base_s = 6'b011111;
    end else if (bus.stallreq_ex) begin
      base_s = 6'b001111;
    end else if (bus.stallreq_id) begin
      base_s = 6'b000111;
    end else begin
      base_s = 6'b000000;
    end
  end

  // A bubble only counts as drained when nothing downstream is holding ID/EX
  assign drain_adv_s = !bus.stallreq_ex && !bus.stallreq_mem;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (bus.exc_req) begin
          next_state_s = ST_FLUSH;
        end else if (bus.halt_req) begin
          next_state_s = ST_DRAIN;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (bus.halt_req) begin
          next_state_s = ST_DRAIN;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (bus.exc_req) begin
          next_state_s = ST_FLUSH;
        end else if (!bus.halt_req) begin
          next_state_s = ST_RUN;
        end else if (drain_adv_s && (cnt_r == CNT_LAST)) begin
          next_state_s = ST_HALTED;
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      ST_HALTED: begin
        if (!bus.halt_req) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_HALTED;
        end
      end
      default: next_state_s = ST_RUN;
    endcase
  end

  // Stall vector and next values of the registered outputs
  always_comb begin
    stall_s      = 6'b000000;
    cnt_nxt_s    = cnt_r;
    new_pc_nxt_s = new_pc_r;
    case (state_r)
      ST_RUN:    stall_s = base_s;
      ST_FLUSH:  stall_s = 6'b000000;
      ST_DRAIN:  stall_s = base_s | 6'b000011;
      ST_HALTED: stall_s = 6'b111111;
      default:   stall_s = 6'b000000;
    endcase
    if (rst) begin
      stall_s = 6'b000000;
    end else begin
      stall_s = stall_s;
    end
    if (next_state_s == ST_FLUSH) begin
      new_pc_nxt_s = bus.exc_pc;
    end else begin
      new_pc_nxt_s = new_pc_r;
    end
    // Any entry into DRAIN (from RUN or FLUSH) restarts the count
    if ((state_r == ST_DRAIN) && (next_state_s == ST_DRAIN)) begin
      if (drain_adv_s) begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end
  end

  // Registered outputs and drain counter
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_r    <= 1'b0;
      halt_ack_r <= 1'b0;
      new_pc_r   <= 32'h0000_0000;
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      flush_r    <= (next_state_s == ST_FLUSH);
      halt_ack_r <= (next_state_s == ST_HALTED);
      new_pc_r   <= new_pc_nxt_s;
      cnt_r      <= cnt_nxt_s;
    end
  end

`ifdef PIPE_STALL_WDOG_EN
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(STALL_MAX);
  localparam logic [WDOG_W-1:0] WDOG_ONE = WDOG_W'(1'b1);

  logic [WDOG_W-1:0] wdog_r;
  logic [WDOG_W-1:0] wdog_nxt_s;
  logic              timeout_r;

  // Consecutive-stall counter, saturating; FLUSH and HALTED are not real stalls
  always_comb begin
    wdog_nxt_s = wdog_r;
    if ((state_r == ST_FLUSH) || (state_r == ST_HALTED) || (base_s == 6'b000000)) begin
      wdog_nxt_s = {WDOG_W{1'b0}};
    end else if (wdog_r != WDOG_MAX) begin
      wdog_nxt_s = wdog_r + WDOG_ONE;
    end else begin
      wdog_nxt_s = wdog_r;
    end
  end

  // Counter register and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_r    <= {WDOG_W{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      wdog_r    <= wdog_nxt_s;
      timeout_r <= timeout_r | (wdog_nxt_s == WDOG_MAX);
    end
  end

  assign bus.stall_timeout = timeout_r;
`else
  logic unused_wdog_cfg_s;
  assign unused_wdog_cfg_s  = ^{32'(STALL_MAX), 32'(WDOG_W)};
  assign bus.stall_timeout  = 1'b0;
`endif

  assign bus.stall    = stall_s;
  assign bus.flush    = flush_r;
  assign bus.new_pc   = new_pc_r;
  assign bus.halt_ack = halt_ack_r;
  assign bus.state_o  = state_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: per-cycle stimulus rows carry their expected outputs,
// queued when driven and popped when the cycle's outputs are sampled on the falling edge.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.DRAIN_CYCLES(4), .CNT_W(3), .STALL_MAX(8), .WDOG_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef PIPE_STALL_WDOG_EN
  localparam logic WD = 1'b1;
`else
  localparam logic WD = 1'b0;
`endif

  // input bits {rst,id,ex,mem,exc,halt}
  localparam logic [5:0] R = 6'b100000, I = 6'b010000, E = 6'b001000;
  localparam logic [5:0] M = 6'b000100, X = 6'b000010, H = 6'b000001, N = 6'b000000;

  typedef struct {
    logic [5:0]  in;
    logic [31:0] pc;
    logic [5:0]  stall;
    logic        fl;
    logic [31:0] npc;
    logic        ack;
    logic [1:0]  st;
    logic        tmo;
  } row_t;

  row_t sb[$];

  function automatic row_t r(input logic [5:0] in, input logic [31:0] pc, input logic [5:0] stall,
                             input logic fl, input logic [31:0] npc, input logic ack, input logic [1:0] st);
    row_t t;
    t.in = in; t.pc = pc; t.stall = stall; t.fl = fl; t.npc = npc; t.ack = ack; t.st = st; t.tmo = 1'b0;
    return t;
  endfunction

  task automatic drive(input row_t t);
    @(posedge clk);
    #1;
    rst              = t.in[5];
    bus.stallreq_id  = t.in[4];
    bus.stallreq_ex  = t.in[3];
    bus.stallreq_mem = t.in[2];
    bus.exc_req      = t.in[1];
    bus.halt_req     = t.in[0];
    bus.exc_pc       = t.pc;
    sb.push_back(t);
  endtask

  task automatic test_reset;
    row_t t[$];
    row_t e;
    t.push_back(r(R | M | X | H, 32'h55, 6'b000000, 1'b0, 32'h0, 1'b0, 2'd0));
    t.push_back(r(R | M | X | H, 32'h55, 6'b000000, 1'b0, 32'h0, 1'b0, 2'd0));
    t.push_back(r(N, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 2'd0));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({bus.stall, bus.flush, bus.halt_ack, bus.state_o, bus.stall_timeout} !== {e.stall, e.fl, e.ack, e.st, e.tmo}
          || bus.new_pc !== 32'h0) begin
        bad++;
        $display("FAIL reset[%0d] got stall=%b fl=%b ack=%b st=%0d tmo=%b pc=%h, want stall=%b fl=%b ack=%b st=%0d tmo=%b pc=0",
                 i, bus.stall, bus.flush, bus.halt_ack, bus.state_o, bus.stall_timeout, bus.new_pc,
                 e.stall, e.fl, e.ack, e.st, e.tmo);
      end
    end
  endtask

  task automatic test_priority;
    row_t t[$];
    row_t e;
    t.push_back(r(I,         32'h0, 6'b000111, 1'b0, 32'h0, 1'b0, 2'd0));
    t.push_back(r(I | E,     32'h0, 6'b001111, 1'b0, 32'h0, 1'b0, 2'd0));
    t.push_back(r(I | E | M, 32'h0, 6'b011111, 1'b0, 32'h0, 1'b0, 2'd0));
    t.push_back(r(M,         32'h0, 6'b011111, 1'b0, 32'h0, 1'b0, 2'd0));
    t.push_back(r(E,         32'h0, 6'b001111, 1'b0, 32'h0, 1'b0, 2'd0));
    t.push_back(r(N,         32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 2'd0));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({bus.stall, bus.flush, bus.halt_ack, bus.state_o, bus.stall_timeout} !== {e.stall, e.fl, e.ack, e.st, e.tmo}
          || (e.fl && bus.new_pc !== e.npc)) begin
        bad++;
        $display("FAIL prio[%0d] got stall=%b fl=%b ack=%b st=%0d tmo=%b pc=%h, want stall=%b fl=%b ack=%b st=%0d tmo=%b pc=%h",
                 i, bus.stall, bus.flush, bus.halt_ack, bus.state_o, bus.stall_timeout, bus.new_pc,
                 e.stall, e.fl, e.ack, e.st, e.tmo, e.npc);
      end
    end
  endtask

  task automatic test_exception;
    row_t t[$];
    row_t e;
    t.push_back(r(X,     32'h120, 6'b000000, 1'b0, 32'h0,   1'b0, 2'd0));
    t.push_back(r(X | I, 32'h999, 6'b000000, 1'b1, 32'h120, 1'b0, 2'd1));
    t.push_back(r(N,     32'h0,   6'b000000, 1'b0, 32'h0,   1'b0, 2'd0));
    t.push_back(r(I,     32'h0,   6'b000111, 1'b0, 32'h0,   1'b0, 2'd0));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({bus.stall, bus.flush, bus.halt_ack, bus.state_o, bus.stall_timeout} !== {e.stall, e.fl, e.ack, e.st, e.tmo}
          || (e.fl && bus.new_pc !== e.npc)) begin
        bad++;
        $display("FAIL exc[%0d] got stall=%b fl=%b ack=%b st=%0d tmo=%b pc=%h, want stall=%b fl=%b ack=%b st=%0d tmo=%b pc=%h",
                 i, bus.stall, bus.flush, bus.halt_ack, bus.state_o, bus.stall_timeout, bus.new_pc,
                 e.stall, e.fl, e.ack, e.st, e.tmo, e.npc);
      end
    end
  endtask

  task automatic test_drain;
    row_t t[$];
    row_t e;
    t.push_back(r(H, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 2'd0));
    for (int k = 0; k < 4; k++) t.push_back(r(H, 32'h0, 6'b000011, 1'b0, 32'h0, 1'b0, 2'd2));
    t.push_back(r(H | X, 32'h77, 6'b111111, 1'b0, 32'h0, 1'b1, 2'd3));
    t.push_back(r(X,     32'h77, 6'b111111, 1'b0, 32'h0, 1'b1, 2'd3));
    t.push_back(r(N,     32'h0,  6'b000000, 1'b0, 32'h0, 1'b0, 2'd0));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({bus.stall, bus.flush, bus.halt_ack, bus.state_o, bus.stall_timeout} !== {e.stall, e.fl, e.ack, e.st, e.tmo}
          || (e.fl && bus.new_pc !== e.npc)) begin
        bad++;
        $display("FAIL drain[%0d] got stall=%b fl=%b ack=%b st=%0d tmo=%b pc=%h, want stall=%b fl=%b ack=%b st=%0d tmo=%b pc=%h",
                 i, bus.stall, bus.flush, bus.halt_ack, bus.state_o, bus.stall_timeout, bus.new_pc,
                 e.stall, e.fl, e.ack, e.st, e.tmo, e.npc);
      end
    end
  endtask

  task automatic test_drain_block;
    row_t t[$];
    row_t e;
    t.push_back(r(H, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 2'd0));
    for (int k = 0; k < 2; k++) t.push_back(r(H,     32'h0, 6'b000011, 1'b0, 32'h0, 1'b0, 2'd2));
    for (int k = 0; k < 3; k++) t.push_back(r(H | M, 32'h0, 6'b011111, 1'b0, 32'h0, 1'b0, 2'd2));
    for (int k = 0; k < 2; k++) t.push_back(r(H,     32'h0, 6'b000011, 1'b0, 32'h0, 1'b0, 2'd2));
    t.push_back(r(H, 32'h0, 6'b111111, 1'b0, 32'h0, 1'b1, 2'd3));
    t.push_back(r(N, 32'h0, 6'b111111, 1'b0, 32'h0, 1'b1, 2'd3));
    t.push_back(r(N, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 2'd0));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({bus.stall, bus.flush, bus.halt_ack, bus.state_o, bus.stall_timeout} !== {e.stall, e.fl, e.ack, e.st, e.tmo}
          || (e.fl && bus.new_pc !== e.npc)) begin
        bad++;
        $display("FAIL dblock[%0d] got stall=%b fl=%b ack=%b st=%0d tmo=%b pc=%h, want stall=%b fl=%b ack=%b st=%0d tmo=%b pc=%h",
                 i, bus.stall, bus.flush, bus.halt_ack, bus.state_o, bus.stall_timeout, bus.new_pc,
                 e.stall, e.fl, e.ack, e.st, e.tmo, e.npc);
      end
    end
  endtask

  task automatic test_drain_abort;
    row_t t[$];
    row_t e;
    t.push_back(r(H, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 2'd0));
    for (int k = 0; k < 2; k++) t.push_back(r(H, 32'h0, 6'b000011, 1'b0, 32'h0, 1'b0, 2'd2));
    t.push_back(r(N, 32'h0, 6'b000011, 1'b0, 32'h0, 1'b0, 2'd2));
    t.push_back(r(N, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 2'd0));
    t.push_back(r(H, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 2'd0));
    for (int k = 0; k < 4; k++) t.push_back(r(H, 32'h0, 6'b000011, 1'b0, 32'h0, 1'b0, 2'd2));
    t.push_back(r(H, 32'h0, 6'b111111, 1'b0, 32'h0, 1'b1, 2'd3));
    t.push_back(r(N, 32'h0, 6'b111111, 1'b0, 32'h0, 1'b1, 2'd3));
    t.push_back(r(N, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 2'd0));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({bus.stall, bus.flush, bus.halt_ack, bus.state_o, bus.stall_timeout} !== {e.stall, e.fl, e.ack, e.st, e.tmo}
          || (e.fl && bus.new_pc !== e.npc)) begin
        bad++;
        $display("FAIL dabort[%0d] got stall=%b fl=%b ack=%b st=%0d tmo=%b pc=%h, want stall=%b fl=%b ack=%b st=%0d tmo=%b pc=%h",
                 i, bus.stall, bus.flush, bus.halt_ack, bus.state_o, bus.stall_timeout, bus.new_pc,
                 e.stall, e.fl, e.ack, e.st, e.tmo, e.npc);
      end
    end
  endtask

  task automatic test_back_to_back;
    row_t t[$];
    row_t e;
    // exception and halt together, then exception in the middle of a drain
    t.push_back(r(X | H, 32'h0000_0abc, 6'b000000, 1'b0, 32'h0,         1'b0, 2'd0));
    t.push_back(r(H,     32'h0,         6'b000000, 1'b1, 32'h0000_0abc, 1'b0, 2'd1));
    for (int k = 0; k < 4; k++) t.push_back(r(H, 32'h0, 6'b000011, 1'b0, 32'h0, 1'b0, 2'd2));
    t.push_back(r(H, 32'h0, 6'b111111, 1'b0, 32'h0, 1'b1, 2'd3));
    t.push_back(r(N, 32'h0, 6'b111111, 1'b0, 32'h0, 1'b1, 2'd3));
    t.push_back(r(H, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 2'd0));
    for (int k = 0; k < 2; k++) t.push_back(r(H, 32'h0, 6'b000011, 1'b0, 32'h0, 1'b0, 2'd2));
    t.push_back(r(H | X, 32'h200, 6'b000011, 1'b0, 32'h0,   1'b0, 2'd2));
    t.push_back(r(H,     32'h0,   6'b000000, 1'b1, 32'h200, 1'b0, 2'd1));
    for (int k = 0; k < 4; k++) t.push_back(r(H, 32'h0, 6'b000011, 1'b0, 32'h0, 1'b0, 2'd2));
    t.push_back(r(H, 32'h0, 6'b111111, 1'b0, 32'h0, 1'b1, 2'd3));
    t.push_back(r(N, 32'h0, 6'b111111, 1'b0, 32'h0, 1'b1, 2'd3));
    t.push_back(r(N, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 2'd0));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({bus.stall, bus.flush, bus.halt_ack, bus.state_o, bus.stall_timeout} !== {e.stall, e.fl, e.ack, e.st, e.tmo}
          || (e.fl && bus.new_pc !== e.npc)) begin
        bad++;
        $display("FAIL b2b[%0d] got stall=%b fl=%b ack=%b st=%0d tmo=%b pc=%h, want stall=%b fl=%b ack=%b st=%0d tmo=%b pc=%h",
                 i, bus.stall, bus.flush, bus.halt_ack, bus.state_o, bus.stall_timeout, bus.new_pc,
                 e.stall, e.fl, e.ack, e.st, e.tmo, e.npc);
      end
    end
  endtask

  task automatic test_mid_reset;
    row_t t[$];
    row_t e;
    t.push_back(r(X, 32'h44, 6'b000000, 1'b0, 32'h0,  1'b0, 2'd0));
    t.push_back(r(R, 32'h0,  6'b000000, 1'b1, 32'h44, 1'b0, 2'd1));
    t.push_back(r(N, 32'h0,  6'b000000, 1'b0, 32'h0,  1'b0, 2'd0));
    t.push_back(r(H, 32'h0,  6'b000000, 1'b0, 32'h0,  1'b0, 2'd0));
    for (int k = 0; k < 4; k++) t.push_back(r(H, 32'h0, 6'b000011, 1'b0, 32'h0, 1'b0, 2'd2));
    t.push_back(r(R | H | M, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b1, 2'd3));
    t.push_back(r(N,         32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 2'd0));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({bus.stall, bus.flush, bus.halt_ack, bus.state_o, bus.stall_timeout} !== {e.stall, e.fl, e.ack, e.st, e.tmo}
          || (e.fl && bus.new_pc !== e.npc)) begin
        bad++;
        $display("FAIL mrst[%0d] got stall=%b fl=%b ack=%b st=%0d tmo=%b pc=%h, want stall=%b fl=%b ack=%b st=%0d tmo=%b pc=%h",
                 i, bus.stall, bus.flush, bus.halt_ack, bus.state_o, bus.stall_timeout, bus.new_pc,
                 e.stall, e.fl, e.ack, e.st, e.tmo, e.npc);
      end
    end
  endtask

  task automatic test_watchdog;
    row_t t[$];
    row_t e;
    row_t w;
    // two broken runs of 5 never trip; an unbroken run of 8 does, one cycle later
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 5; j++) t.push_back(r(E, 32'h0, 6'b001111, 1'b0, 32'h0, 1'b0, 2'd0));
      t.push_back(r(N, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 2'd0));
    end
    for (int j = 0; j < 8; j++) t.push_back(r(E, 32'h0, 6'b001111, 1'b0, 32'h0, 1'b0, 2'd0));
    for (int j = 0; j < 2; j++) begin
      w = r(N, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 2'd0);
      w.tmo = WD;
      t.push_back(w);
    end
    w = r(R, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 2'd0);
    w.tmo = WD;
    t.push_back(w);
    t.push_back(r(N, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 2'd0));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({bus.stall, bus.flush, bus.halt_ack, bus.state_o, bus.stall_timeout} !== {e.stall, e.fl, e.ack, e.st, e.tmo}
          || (e.fl && bus.new_pc !== e.npc)) begin
        bad++;
        $display("FAIL wdog[%0d] got stall=%b fl=%b ack=%b st=%0d tmo=%b pc=%h, want stall=%b fl=%b ack=%b st=%0d tmo=%b pc=%h",
                 i, bus.stall, bus.flush, bus.halt_ack, bus.state_o, bus.stall_timeout, bus.new_pc,
                 e.stall, e.fl, e.ack, e.st, e.tmo, e.npc);
      end
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus.stallreq_id  = 1'b0;
    bus.stallreq_ex  = 1'b0;
    bus.stallreq_mem = 1'b0;
    bus.exc_req      = 1'b0;
    bus.exc_pc       = 32'h0;
    bus.halt_req     = 1'b0;
    test_reset();
    test_priority();
    test_exception();
    test_drain();
    test_drain_block();
    test_drain_abort();
    test_back_to_back();
    test_mid_reset();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the five-stage core. It drives the per-stage stall vector that gates the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also issues pipeline flushes with a redirect PC on exceptions and runs a halt/drain handshake for debug and power control. It sits beside the pipeline registers and feeds their stall/flush inputs and the PC register.

Parameters:
DRAIN_CYCLES, 4, number of bubble-clean cycles required before reporting halted
CNT_W, 3, width of the drain counter; must hold DRAIN_CYCLES
STALL_MAX, 255, consecutive stalled cycles that trip the watchdog (only with PIPE_STALL_WDOG_EN)
WDOG_W, 8, width of the watchdog counter; must hold STALL_MAX

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
stallreq_id  input  1  ID-stage hazard stall request
stallreq_ex  input  1  EX-stage multi-cycle stall request
stallreq_mem  input  1  MEM-stage memory-wait stall request
exc_req  input  1  exception committed at MEM stage
exc_pc  input  32  handler address accompanying exc_req
halt_req  input  1  level request to halt the pipeline
stall  output  6  [0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB, [5]=WB
flush  output  1  registered one-cycle flush pulse to all pipeline registers
new_pc  output  32  redirect PC, valid while flush=1
halt_ack  output  1  pipeline drained and frozen
state_o  output  2  current FSM state: 0 RUN, 1 FLUSH, 2 DRAIN, 3 HALTED
stall_timeout  output  1  sticky watchdog flag

Behaviour:
- Reset (rst=1 at posedge): state=RUN, flush=0, new_pc=0x00000000, halt_ack=0, drain counter=0, watchdog counter=0, stall_timeout=0. The stall output is combinational and equals 6'b000000 while rst=1.
- Base stall is combinational, with zero latency, priority mem > ex > id:
  - stallreq_mem gives 6'b011111.
  - else stallreq_ex gives 6'b001111.
  - else stallreq_id gives 6'b000111.
  - else 6'b000000.
- RUN state:
  - stall = base stall.
  - If exc_req=1: next state FLUSH. On that edge, register flush<=1 and new_pc<=exc_pc.
  - Else if halt_req=1: next state DRAIN, and clear the drain counter.
  - Exception wins over halt in the same cycle.
- FLUSH state (exactly 1 cycle):
  - flush=1, stall=6'b000000, exc_req ignored.
  - Next edge: flush<=0. new_pc holds its value (do not care once flush=0).
  - Next state is DRAIN (counter cleared) if halt_req=1, else RUN.
- DRAIN state:
  - stall = base stall OR 6'b000011. PC and IF/ID are frozen while ID/EX advances, so bubbles are injected.
  - The counter increments on each cycle where stallreq_ex=0 and stallreq_mem=0. It holds otherwise.
  - When the counter reaches DRAIN_CYCLES-1 and increments, next state is HALTED and halt_ack<=1.
  - exc_req=1 goes to FLUSH, as in RUN; the counter restarts on return.
  - halt_req deasserted goes to RUN, and the counter clears.
- HALTED state:
  - stall=6'b111111, halt_ack=1.
  - exc_req is ignored, because the pipeline is empty.
  - halt_req=0 goes to RUN; halt_ack<=0 on the same edge.
- halt_ack is registered; it rises one cycle after the last drain count.
- state_o reflects the registered state.
- A mid-operation reset returns to RUN from any state on the next edge, with all registered outputs cleared.

Optional Feature:
Macro PIPE_STALL_WDOG_EN.
- Defined:
  - A WDOG_W counter increments on each cycle where the base stall is nonzero, saturating at STALL_MAX.
  - The counter clears on any cycle with base stall zero, and in FLUSH or HALTED.
  - On reaching STALL_MAX, stall_timeout<=1, sticky until rst.
- Not defined: stall_timeout is tied to 0 and no counter logic is generated.

Test Plan:
- Stall priority: stallreq_id=1 -> stall=6'b000111; add stallreq_ex=1 -> 6'b001111; add stallreq_mem=1 -> 6'b011111, all in the same cycle, no latency.
- Exception: in RUN, exc_req=1 with exc_pc=0x00000120 for one cycle -> next cycle flush=1, new_pc=0x00000120, stall=0, state_o=1; the following cycle flush=0, state_o=0.
- Drain/halt: halt_req=1 held, no stall requests -> stall=6'b000011 for 4 cycles, then halt_ack=1, stall=6'b111111, state_o=3. Drop halt_req -> next cycle halt_ack=0, state_o=0.
- Drain blocking: during DRAIN, stallreq_mem=1 for 3 cycles mid-count -> counter holds; halt_ack is delayed exactly 3 cycles (7 cycles total).
- Simultaneous events: exc_req=1 and halt_req=1 in the same RUN cycle -> FLUSH first (flush=1, new_pc=exc_pc), then DRAIN with the counter restarted, then HALTED after 4 more cycles.
- Watchdog (macro defined, STALL_MAX=8): stallreq_ex held 8 cycles -> stall_timeout=1 and stays 1 after the request drops; rst clears it. Macro undefined -> stays 0.
